// File: rtl/cmp_result_display.sv
// cmp_result_display: samples the 2-bit comparator operands and flags once per
// display frame, validates the flags and drives the 4-digit seven-segment scan
// (A, B, blank, result glyph). Keeps a saturating count of invalid samples.
// Optional feature macro: CMP_DISP_CHECK_EN adds a check that the flag agrees
// with the captured operands.
module cmp_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       less,
  input  logic       equal,
  input  logic       greater,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_EQ    = 7'b0110111;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [CW-1:0] ref_cnt;
  logic [1:0]    digit_sel;
  logic [1:0]    a_q, b_q;
  logic [2:0]    flags_q;
  logic          err_q;
  logic [7:0]    cnt_q;

  logic [2:0] flags_in;
  logic       ref_wrap, sample;
  logic       onehot_bad, mismatch, sample_bad;

  assign flags_in = {less, equal, greater};
  assign ref_wrap = (ref_cnt == REF_LAST);
  // End of frame: last cycle of the last digit slot.
  assign sample   = ref_wrap && (digit_sel == 2'd3);

  // Flag validity of the value being captured this cycle
  always_comb begin
    onehot_bad = 1'b1;
    case (flags_in)
      3'b100, 3'b010, 3'b001: onehot_bad = 1'b0;
      default:                onehot_bad = 1'b1;
    endcase
  end

`ifdef CMP_DISP_CHECK_EN
  assign mismatch = (less && (a >= b)) || (equal && (a != b)) || (greater && (a <= b));
`else
  assign mismatch = 1'b0;
`endif

  assign sample_bad = onehot_bad | mismatch;

  // Refresh timing, digit scan and end-of-frame capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt   <= '0;
      digit_sel <= 2'd0;
      a_q       <= 2'd0;
      b_q       <= 2'd0;
      flags_q   <= 3'b010;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + CW'(1);
      if (ref_wrap) digit_sel <= digit_sel + 2'd1;
      if (sample) begin
        a_q     <= a;
        b_q     <= b;
        flags_q <= flags_in;
        err_q   <= sample_bad;
        if (sample_bad && (cnt_q != 8'hff)) cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  function automatic logic [6:0] hex_glyph(input logic [1:0] v);
    case (v)
      2'd0:    hex_glyph = 7'b1000000;
      2'd1:    hex_glyph = 7'b1111001;
      2'd2:    hex_glyph = 7'b0100100;
      default: hex_glyph = 7'b0110000;
    endcase
  endfunction

  logic [6:0] res_glyph;

  // Result glyph: invalid overrides, otherwise the one-hot flag picks L/=/G
  always_comb begin
    res_glyph = SEG_DASH;
    if (!err_q) begin
      case (flags_q)
        3'b100:  res_glyph = SEG_L;
        3'b010:  res_glyph = SEG_EQ;
        3'b001:  res_glyph = SEG_G;
        default: res_glyph = SEG_DASH;
      endcase
    end
  end

  // Display decode from registered state only
  always_comb begin
    an  = 4'b1110;
    seg = res_glyph;
    dp  = 1'b1;
    case (digit_sel)
      2'd0: begin
        an  = 4'b1110;
        seg = res_glyph;
        dp  = ~err_q;
      end
      2'd1: begin
        an  = 4'b1101;
        seg = SEG_BLANK;
      end
      2'd2: begin
        an  = 4'b1011;
        seg = hex_glyph(b_q);
      end
      default: begin
        an  = 4'b0111;
        seg = hex_glyph(a_q);
      end
    endcase
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_result_display.sv
// Scoreboard bench for cmp_result_display with REFRESH_DIV=4 (16-cycle frame).
// A reference model pushes the expected displayed content at every sample
// event; a monitor pops it and checks the scan outputs every cycle.
module tb_cmp_result_display;
  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a = 2'd0, b = 2'd0;
  logic       less = 1'b0, equal = 1'b1, greater = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, err;
  logic [7:0] err_cnt;

  cmp_result_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .less(less), .equal(equal), .greater(greater),
    .an(an), .seg(seg), .dp(dp), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] fl;
    logic       e;
    logic [7:0] cnt;
  } item_t;

  item_t q[$];
  item_t cur;
  int    phase  = 0;   // cycle position within the frame, 0..15
  int    nerr   = 0;   // invalid samples since reset (unsaturated)
  bit    mon_en = 1'b0;
  int    checks = 0, passed = 0;

  function automatic bit is_invalid(input logic [1:0] va, input logic [1:0] vb,
                                    input logic [2:0] fl);
    if ($countones(fl) != 1) return 1'b1;
`ifdef CMP_DISP_CHECK_EN
    if (fl == 3'b100 && !(va < vb))  return 1'b1;
    if (fl == 3'b010 && !(va == vb)) return 1'b1;
    if (fl == 3'b001 && !(va > vb))  return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [6:0] hexg(input logic [1:0] v);
    logic [6:0] t [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
    return t[v];
  endfunction

  function automatic logic [6:0] resg(input item_t it);
    if (it.e) return 7'b0111111;
    if (it.fl == 3'b100) return 7'b1000111;
    if (it.fl == 3'b010) return 7'b0110111;
    return 7'b1000010;
  endfunction

  // Reference model: what the display should show after each capture
  always @(posedge clk) begin
    item_t it;
    if (rst) begin
      phase = 0;
      nerr  = 0;
      q.delete();
      it = '{a: 2'd0, b: 2'd0, fl: 3'b010, e: 1'b0, cnt: 8'd0};
      q.push_back(it);
    end else begin
      if (phase == FRAME - 1) begin
        it.a  = a;
        it.b  = b;
        it.fl = {less, equal, greater};
        it.e  = is_invalid(a, b, {less, equal, greater});
        if (it.e) nerr++;
        it.cnt = (nerr > 255) ? 8'd255 : 8'(nerr);
        q.push_back(it);
      end
      phase = (phase + 1) % FRAME;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Monitor: take the newest expected content, then check all outputs
  always @(negedge clk) begin
    int d;
    logic [3:0] ean;
    logic [6:0] eseg;
    if (mon_en) begin
      while (q.size() > 0) cur = q.pop_front();
      d = phase / RD;
      ean  = 4'b1111 & ~(4'b0001 << d);
      case (d)
        0:       eseg = resg(cur);
        1:       eseg = 7'b1111111;
        2:       eseg = hexg(cur.b);
        default: eseg = hexg(cur.a);
      endcase
      chk("an",      an,      ean);
      chk("seg",     seg,     eseg);
      chk("dp",      dp,      (d == 0 && cur.e) ? 0 : 1);
      chk("err",     err,     cur.e);
      chk("err_cnt", err_cnt, cur.cnt);
    end
  end

  task automatic set_in(input logic [1:0] va, input logic [1:0] vb, input logic [2:0] fl);
    a = va; b = vb; {less, equal, greater} = fl;
  endtask

  task automatic frame(input logic [1:0] va, input logic [1:0] vb, input logic [2:0] fl);
    set_in(va, vb, fl);
    repeat (FRAME) @(negedge clk);
  endtask

  task automatic rand_in();
    logic [1:0] va, vb;
    logic [2:0] fl;
    va = 2'($urandom_range(0, 3));
    vb = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0)
      fl = (va < vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
    else
      fl = 3'($urandom_range(0, 7));
    set_in(va, vb, fl);
  endtask

  // Random frames with inputs also changing mid-frame and in the sample cycle
  task automatic rand_frames(input int n);
    for (int f = 0; f < n; f++) begin
      rand_in();
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) rand_in();
      end
    end
  endtask

  task automatic wait_phase(input int p);
    int guard = 0;
    while (phase != p && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_phase_timeout", phase, p);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    frame(2'd0, 2'd0, 3'b010);      // free-run scan with reset content
    frame(2'd2, 2'd1, 3'b001);      // valid A>B
    frame(2'd1, 2'd2, 3'b011);      // invalid flags, three frames
    frame(2'd1, 2'd2, 3'b011);
    frame(2'd1, 2'd2, 3'b011);
    frame(2'd3, 2'd3, 3'b010);      // valid equal, count holds
    frame(2'd1, 2'd2, 3'b001);      // flag disagrees with operands
    frame(2'd0, 2'd3, 3'b100);
    rand_frames(40);

    set_in(2'd1, 2'd1, 3'b111);     // drive the counter into saturation
    repeat (300 * FRAME) @(negedge clk);
    frame(2'd2, 2'd2, 3'b010);
    frame(2'd1, 2'd1, 3'b000);      // invalid at 255 stays 255

    frame(2'd3, 2'd0, 3'b001);      // capture a=3, then reset mid-frame
    wait_phase(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame(2'd1, 2'd0, 3'b001);
    frame(2'd0, 2'd0, 3'b110);

    wait_phase(FRAME - 1);          // reset lands on a sample-event edge
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame(2'd2, 2'd3, 3'b100);
    rand_frames(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
